// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the ALU sharing arbiter: ALU op encoding,
//               arbiter FSM states, condition-code bit positions and helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        ALUK_ADD   = 2'd0,
        ALUK_AND   = 2'd1,
        ALUK_XOR   = 2'd2,
        ALUK_PASSA = 2'd3
    } aluk_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int CC_N = 2;
    localparam int CC_Z = 1;
    localparam int CC_P = 0;

    // One-hot {N,Z,P}: zero wins over sign since a zero result has msb clear.
    function automatic logic [2:0] cc_of(input logic i_msb, input logic i_zero);
        logic [2:0] w_cc;
        w_cc = '0;
        if (i_zero)     w_cc[CC_Z] = 1'b1;
        else if (i_msb) w_cc[CC_N] = 1'b1;
        else            w_cc[CC_P] = 1'b1;
        return w_cc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb_if
// Description : Requester, ALU and response signals of the ALU sharing
//               arbiter. rsp_cc exists only when ALU_SHARE_CC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arb_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_aluk;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_aluk;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_aluk;
    logic [WIDTH-1:0] alu_out;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp_data;
`ifdef ALU_SHARE_CC_EN
    logic [2:0]       rsp_cc;
`endif

    // Requesters plus the ALU beside the arbiter.
    modport master (
`ifdef ALU_SHARE_CC_EN
        input  rsp_cc,
`endif
        output req0_valid, req0_a, req0_b, req0_aluk,
        output req1_valid, req1_a, req1_b, req1_aluk,
        output alu_out,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_aluk,
        input  rsp0_valid, rsp1_valid, rsp_data
    );

    modport slave (
`ifdef ALU_SHARE_CC_EN
        output rsp_cc,
`endif
        input  req0_valid, req0_a, req0_b, req0_aluk,
        input  req1_valid, req1_a, req1_b, req1_aluk,
        input  alu_out,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_aluk,
        output rsp0_valid, rsp1_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arb_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin pick; on a tie the requester that did
//               not win last time is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  wire logic i_valid0,
    input  wire logic i_valid1,
    input  wire logic i_last,
    output logic      o_grant0,
    output logic      o_grant1
);
    assign o_grant0 = i_valid0 & (~i_valid1 |  i_last);
    assign o_grant1 = i_valid1 & (~i_valid0 | ~i_last);
endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Round-robin arbiter/sequencer for a shared combinational ALU.
//               Optional {N,Z,P} response flags via macro ALU_SHARE_CC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    alu_share_arb_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic             r_grant_id;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    aluk_t            r_alu_aluk;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic             w_g0;
    logic             w_g1;
    logic             w_accept;
    logic             w_hs;

    rr_pick2 u_pick (
        .i_valid0 (bus.req0_valid),
        .i_valid1 (bus.req1_valid),
        .i_last   (r_last),
        .o_grant0 (w_g0),
        .o_grant1 (w_g1)
    );

    always_comb begin
        w_accept    = (r_state != ST_EXEC);
        w_hs        = w_accept & (w_g0 | w_g1);
        w_state_nxt = r_state;
        case (r_state)
            ST_EXEC: w_state_nxt = ST_RESP;
            default: w_state_nxt = w_hs ? ST_EXEC : ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last       <= 1'b1;
            r_grant_id   <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_aluk   <= ALUK_ADD;
            r_rsp_data   <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rsp0_valid <= (r_state == ST_EXEC) & ~r_grant_id;
            r_rsp1_valid <= (r_state == ST_EXEC) &  r_grant_id;
            if (w_hs) begin
                r_alu_a    <= w_g1 ? bus.req1_a : bus.req0_a;
                r_alu_b    <= w_g1 ? bus.req1_b : bus.req0_b;
                r_alu_aluk <= aluk_t'(w_g1 ? bus.req1_aluk : bus.req0_aluk);
                r_grant_id <= w_g1;
                r_last     <= w_g1;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data <= bus.alu_out;
            end
        end
    end

`ifdef ALU_SHARE_CC_EN
    logic [2:0] r_rsp_cc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_cc <= 3'b010;
        end else if (r_state == ST_EXEC) begin
            r_rsp_cc <= cc_of(bus.alu_out[WIDTH-1], (bus.alu_out == '0));
        end
    end

    assign bus.rsp_cc = r_rsp_cc;
`endif

    assign bus.req0_ready = w_accept & w_g0;
    assign bus.req1_ready = w_accept & w_g1;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_aluk   = r_alu_aluk;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp_data   = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arb
// Description : Directed self-checking bench for alu_share_arb with a
//               transaction-level reference model and a reference ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arb_if #(.WIDTH(W)) bus ();

    alu_share_arb #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [15:0] alu_ref(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
        case (k)
            2'd0:    return a + b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return a;
        endcase
    endfunction

    function automatic logic [2:0] cc_ref(input logic [15:0] d);
        if (d == 16'h0000) return 3'b010;
        if (d[15])         return 3'b100;
        return 3'b001;
    endfunction

    always_comb bus.alu_out = alu_ref(bus.alu_aluk, bus.alu_a, bus.alu_b);

    typedef struct { logic [1:0] k; logic [15:0] a; logic [15:0] b; } op_t;
    typedef struct { int due; int id; logic [15:0] d; } exp_t;
    typedef struct { int cyc; int id; logic [15:0] d; logic [2:0] cc; } log_t;

    op_t  q0[$];
    op_t  q1[$];
    exp_t mq[$];
    log_t lg[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic hs0    = 1'b0;
    logic hs1    = 1'b0;

    // model state
    int          m_last    = 1;
    int          m_last_hs = -100;
    int          m_pdue    = -1;
    logic [15:0] m_pa, m_pb, m_alu_a, m_alu_b, m_rsp_data;
    logic [1:0]  m_pk, m_alu_k;
    logic [2:0]  m_cc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Driver: one op per requester in flight, reloaded right after its handshake.
    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_aluk = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_aluk = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end else begin
                if (bus.req0_valid && hs0) bus.req0_valid = 1'b0;
                if (bus.req1_valid && hs1) bus.req1_valid = 1'b0;
                if (!bus.req0_valid && q0.size() > 0) begin
                    op_t o;
                    o = q0.pop_front();
                    bus.req0_a = o.a; bus.req0_b = o.b; bus.req0_aluk = o.k;
                    bus.req0_valid = 1'b1;
                end
                if (!bus.req1_valid && q1.size() > 0) begin
                    op_t o;
                    o = q1.pop_front();
                    bus.req1_a = o.a; bus.req1_b = o.b; bus.req1_aluk = o.k;
                    bus.req1_valid = 1'b1;
                end
            end
        end
    end

    // Model + compare on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_last = 1; m_last_hs = -100; m_pdue = -1; mq.delete();
                m_alu_a = '0; m_alu_b = '0; m_alu_k = '0; m_rsp_data = '0; m_cc = 3'b010;
                hs0 = 1'b0; hs1 = 1'b0;
                chk("rst_alu_a", 32'(bus.alu_a), 32'h0);
                chk("rst_alu_b", 32'(bus.alu_b), 32'h0);
                chk("rst_alu_aluk", 32'(bus.alu_aluk), 32'h0);
                chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
                chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
                chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
`ifdef ALU_SHARE_CC_EN
                chk("rst_rsp_cc", 32'(bus.rsp_cc), 32'h2);
`endif
            end else begin
                logic e0, e1, er0, er1, free;
                if (m_pdue == cyc) begin
                    m_alu_a = m_pa; m_alu_b = m_pb; m_alu_k = m_pk;
                end
                e0 = 1'b0; e1 = 1'b0;
                if (mq.size() > 0 && mq[0].due == cyc) begin
                    exp_t x;
                    logic [2:0] acc;
                    x = mq.pop_front();
                    if (x.id == 0) e0 = 1'b1; else e1 = 1'b1;
                    m_rsp_data = x.d;
                    m_cc = cc_ref(x.d);
`ifdef ALU_SHARE_CC_EN
                    acc = bus.rsp_cc;
`else
                    acc = cc_ref(bus.rsp_data);
`endif
                    lg.push_back('{cyc, x.id, bus.rsp_data, acc});
                end
                free = (cyc != m_last_hs + 1);
                er0 = free && bus.req0_valid && (!bus.req1_valid || m_last == 1);
                er1 = free && bus.req1_valid && (!bus.req0_valid || m_last == 0);
                chk("req0_ready", 32'(bus.req0_ready), 32'(er0));
                chk("req1_ready", 32'(bus.req1_ready), 32'(er1));
                chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(e0));
                chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(e1));
                chk("rsp_data", 32'(bus.rsp_data), 32'(m_rsp_data));
                chk("alu_a", 32'(bus.alu_a), 32'(m_alu_a));
                chk("alu_b", 32'(bus.alu_b), 32'(m_alu_b));
                chk("alu_aluk", 32'(bus.alu_aluk), 32'(m_alu_k));
`ifdef ALU_SHARE_CC_EN
                chk("rsp_cc", 32'(bus.rsp_cc), 32'(m_cc));
`endif
                hs0 = bus.req0_valid && bus.req0_ready;
                hs1 = bus.req1_valid && bus.req1_ready;
                if (er0 || er1) begin
                    int w;
                    w = er1 ? 1 : 0;
                    m_last = w; m_last_hs = cyc; m_pdue = cyc + 1;
                    m_pa = w ? bus.req1_a : bus.req0_a;
                    m_pb = w ? bus.req1_b : bus.req0_b;
                    m_pk = w ? bus.req1_aluk : bus.req0_aluk;
                    mq.push_back('{cyc + 2, w, alu_ref(m_pk, m_pa, m_pb)});
                end
            end
        end
    end

    task automatic do_reset();
        q0.delete(); q1.delete();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        lg.delete();
    endtask

    task automatic run_ops(input int maxc);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || bus.req0_valid || bus.req1_valid || mq.size() != 0) && n < maxc) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= maxc) begin
            checks++; errors++;
            $display("FAIL run_timeout: got %0d cycles expected < %0d", n, maxc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_log(input string nm, input int idx, input int id, input logic [15:0] d, input logic [2:0] cc);
        if (idx >= lg.size()) begin
            checks++; errors++;
            $display("FAIL %s: got %0d responses expected > %0d", nm, lg.size(), idx);
        end else begin
            chk({nm, "_id"}, 32'(lg[idx].id), 32'(id));
            chk({nm, "_data"}, 32'(lg[idx].d), 32'(d));
`ifdef ALU_SHARE_CC_EN
            chk({nm, "_cc"}, 32'(lg[idx].cc), 32'(cc));
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // ADD with signed overflow into the msb
        do_reset();
        q0.push_back('{2'd0, 16'h7FFF, 16'h0001});
        run_ops(50);
        chk_log("add_ovf", 0, 0, 16'h8000, 3'b100);

        // tie at the first cycle after reset: req0 first, req1 in req0's RESP cycle
        do_reset();
        q0.push_back('{2'd1, 16'hF0F0, 16'h0FF0});
        q1.push_back('{2'd2, 16'hAAAA, 16'hAAAA});
        run_ops(50);
        chk_log("tie_r0", 0, 0, 16'h00F0, 3'b001);
        chk_log("tie_r1", 1, 1, 16'h0000, 3'b010);
        if (lg.size() >= 2) chk("tie_gap", 32'(lg[1].cyc - lg[0].cyc), 32'd2);

        // back-to-back contention: strict alternation, one response every 2 cycles
        lg.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{2'd0, 16'(16'h0100 * i), 16'h0001});
            q1.push_back('{2'd2, 16'hFF00, 16'(i)});
        end
        run_ops(100);
        chk("rr_count", 32'(lg.size()), 32'd8);
        for (int i = 0; i < 8 && i < lg.size(); i++) begin
            chk("rr_id", 32'(lg[i].id), 32'(i % 2));
            chk("rr_data", 32'(lg[i].d), (i % 2 == 0) ? 32'(16'h0100 * (i / 2) + 1) : 32'(16'hFF00 ^ (i / 2)));
            if (i > 0) chk("rr_gap", 32'(lg[i].cyc - lg[i-1].cyc), 32'd2);
        end

        // wrap and PASSA
        lg.delete();
        q0.push_back('{2'd0, 16'hFFFF, 16'h0001});
        q1.push_back('{2'd3, 16'h1234, 16'hFFFF});
        run_ops(50);
        chk_log("add_wrap", 0, 0, 16'h0000, 3'b010);
        chk_log("passa", 1, 1, 16'h1234, 3'b001);

        // reset during EXEC loses the op
        lg.delete();
        q0.push_back('{2'd0, 16'h1111, 16'h2222});
        begin
            int n = 0;
            while (!hs0 && n < 20) begin
                @(negedge clk); #1;
                n++;
            end
            if (n >= 20) begin
                checks++; errors++;
                $display("FAIL abort_hs_timeout: got %0d cycles expected < 20", n);
            end
        end
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_rsp", 32'(lg.size()), 32'd0);
        q1.push_back('{2'd0, 16'h0003, 16'h0004});
        run_ops(50);
        chk_log("post_abort", 0, 1, 16'h0007, 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the shared 16-bit combinational ALU (ADD/AND/XOR/PASSA on `ALUK`). It sits between the ALU and its two users: requester 0 is the execute datapath, requester 1 is the address/increment path. It accepts one operation per handshake, registers the operands into the ALU's inputs, captures the ALU result, and returns it to the winner as a one-cycle response. Arbitration is round-robin.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; must match the ALU.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  operation requested.
- `req0_ready` / `req1_ready`  out  1  grant; transfer when valid && ready.
- `req0_a` / `req1_a`, `req0_b` / `req1_b`  in  WIDTH  operands.
- `req0_aluk` / `req1_aluk`  in  2  op: 0 ADD, 1 AND, 2 XOR, 3 PASSA.
- `alu_a`, `alu_b`  out  WIDTH  registered ALU operands.
- `alu_aluk`  out  2  registered ALU op.
- `alu_out`  in  WIDTH  ALU result (combinational from `alu_*`).
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle result pulse.
- `rsp_data`  out  WIDTH  result, shared by both response channels.
- `rsp_cc`  out  3  {N,Z,P}. Present only with `ALU_SHARE_CC_EN`.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE or RESP:
  - Winner = requester with valid set; if both, the one ≠ `last_grant`.
  - `reqX_ready` is asserted combinationally for the winner only.
  - On handshake: latch a/b/aluk into `alu_a`/`alu_b`/`alu_aluk`, record `grant_id`, set `last_grant`, next state EXEC.
  - No request: IDLE.
- EXEC: `alu_out` is captured into `rsp_data` at the end of the cycle → RESP.
- RESP:
  - `rsp<grant_id>_valid` = 1 for exactly one cycle; no backpressure on responses.
  - The state accepts a new request with the same rules as IDLE.
- `ready` is never asserted in EXEC.
- Requesters hold valid and operands stable until ready; the arbiter samples them only at the handshake.
- `alu_*` and `rsp_data` hold their last values between operations.
- Arithmetic: ADD wraps modulo 2^WIDTH, carry discarded. The arbiter never modifies `alu_out`.
- PASSA: `alu_b` is still latched from `reqX_b`; the ALU ignores it.
- Reset values:
  - `alu_a`, `alu_b`, `alu_aluk`, `rsp_data`: 0.
  - `rspX_valid`: 0.
  - `last_grant`: 1, so requester 0 wins the first tie.
  - `rsp_cc`: 3'b010.
- Reset asserted mid-operation aborts it: no response is issued and the in-flight op is lost.

## Timing
- Handshake in cycle N → EXEC in N+1 → `rspX_valid`/`rsp_data` in N+2.
- Next handshake is possible in N+2, giving a sustained throughput of one op per 2 cycles.
- Ready depends combinationally on both valids and the state; there is no combinational path from `alu_out` to any output.
- `alu_*` outputs change only on the clock edge ending a handshake cycle.

## Configuration
- `ALU_SHARE_CC_EN` defined: `rsp_cc` port exists.
  - Registered alongside `rsp_data` from the captured result.
  - N = msb, Z = all-zero, P otherwise; exactly one bit set.
- Not defined: no `rsp_cc` port and no CC logic; all other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - `aluk_t` enum: ADD=0, AND=1, XOR=2, PASSA=3.
  - FSM state typedef.
  - CC bit positions.
- One sub-module, `rr_pick2`: combinational two-way round-robin (valid0, valid1, last → grant0, grant1).
- The ALU is instantiated beside the arbiter, not inside it.

## Test plan
- After reset, check reset values (`alu_*` = 0, `rsp_cc` = 010). Then req0 ADD 0x7FFF + 0x0001 handshakes at N → `rsp0_valid` at N+2, `rsp_data` = 0x8000, `rsp_cc` = 100.
- Both valid at the first cycle after reset: req0 AND 0xF0F0 & 0x0FF0, req1 XOR 0xAAAA ^ 0xAAAA.
  - req0 is granted first and receives 0x00F0.
  - req1 is granted in req0's RESP cycle and receives 0x0000 with `rsp_cc` = 010.
- Both held valid continuously for 8 ops → grants alternate 0, 1, 0, 1…; one response every 2 cycles; no double grant.
- ADD 0xFFFF + 0x0001 → 0x0000 (wrap); PASSA a = 0x1234, b = 0xFFFF → 0x1234.
- `rst_n` low during EXEC → no `rspX_valid` pulse. After release, all outputs are at reset values and the next request is served normally.
